// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared pipeline constants and fetch sequencer state encodings
package fetch_sequencer_pkg;

  // Pipeline-wide constants
  localparam int INSTR_W  = 32;
  localparam int RESET_PC = 0;

  // Cycles needed to empty the pipeline once a halt opcode has been fetched
  localparam int DRAIN_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_drain_timer.sv
// rtl/fetch_sequencer_drain_timer.sv - loadable down-counter with zero flag for the drain phase
module drain_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load takes precedence over decrement; the counter saturates at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - debug-controlled fetch FSM driving PC stall/redirect and pipeline flushes
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dbg_run,
  input  logic              dbg_step,
  input  logic              dbg_halt,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt_fetched,
  output logic              pc_stall,
  output logic              pc_use_npc,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [2:0]        state_o,
  output logic [31:0]       cycle_count
);

  // Timer holds DRAIN_CYCLES-1 on entry so DRAIN lasts DRAIN_CYCLES cycles ending on zero
  localparam int TW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  fetch_state_e state;
  logic         drain_load;
  logic         drain_dec;
  logic         drain_zero;
  logic         active;

  assign active     = (state == S_RUN) || (state == S_STEP);
  assign drain_load = (state == S_RUN) && !dbg_halt && dbg_run && halt_fetched;
  assign drain_dec  = (state == S_DRAIN) && !dbg_halt;
  assign state_o    = state;

  drain_timer #(.WIDTH(TW)) u_drain_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (drain_load),
    .load_value (TW'(DRAIN_CYCLES - 1)),
    .dec        (drain_dec),
    .zero       (drain_zero)
  );

  // Debug command sequencing; DONE is terminal until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_HALTED;
    end else begin
      case (state)
        S_HALTED: begin
          if (dbg_step)     state <= S_STEP;
          else if (dbg_run) state <= S_RUN;
        end
        S_STEP:   state <= S_HALTED;
        S_RUN: begin
          if (dbg_halt || !dbg_run) state <= S_HALTED;
          else if (halt_fetched)    state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (dbg_halt)        state <= S_HALTED;
          else if (drain_zero) state <= S_DONE;
        end
        S_DONE:   state <= S_DONE;
        default:  state <= S_HALTED;
      endcase
    end
  end

  // Executing-cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (active || (state == S_DRAIN)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Zero-latency PC control; redirects only while active, reset forces halted values
  always_comb begin
    pc_stall    = 1'b1;
    pc_use_npc  = 1'b1;
    pc_target   = '0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!reset) begin
      if (active) begin
        if (branch_taken) begin
          pc_stall    = 1'b0;
          pc_use_npc  = 1'b0;
          pc_target   = branch_target;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (jump_valid) begin
          pc_stall    = 1'b0;
          pc_use_npc  = 1'b0;
          pc_target   = jump_target;
          flush_if_id = 1'b1;
        end else if (hazard_stall) begin
          flush_id_ex = 1'b1;
        end else begin
          pc_stall    = 1'b0;
        end
      end else if (state == S_DRAIN) begin
        flush_if_id = 1'b1;
      end
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, giving the number of cycles to flush the pipeline after a halt instruction is fetched.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the width of the instruction address.
REQ-003 SHALL have port clock  in  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port dbg_run  in  1  debug command: free-run; level, sampled each cycle.
REQ-006 SHALL have port dbg_step  in  1  debug command: execute one cycle; one-cycle pulse.
REQ-007 SHALL have port dbg_halt  in  1  debug command: stop fetch immediately; one-cycle pulse.
REQ-008 SHALL have port hazard_stall  in  1  load-use hazard request from the ID stage.
REQ-009 SHALL have port branch_taken  in  1  branch resolved taken in EX.
REQ-010 SHALL have port branch_target  in  ADDR_W  branch destination.
REQ-011 SHALL have port jump_valid  in  1  unconditional jump decoded in ID.
REQ-012 SHALL have port jump_target  in  ADDR_W  jump destination.
REQ-013 SHALL have port halt_fetched  in  1  halt opcode present in IF/ID.
REQ-014 SHALL have port pc_stall  out  1  drives the PC stall input.
REQ-015 SHALL have port pc_use_npc  out  1  drives the PC sequential/redirect select; 1 = sequential, 0 = load pc_target.
REQ-016 SHALL have port pc_target  out  ADDR_W  drives the PC jump-address input.
REQ-017 SHALL have port flush_if_id  out  1  bubble IF/ID register.
REQ-018 SHALL have port flush_id_ex  out  1  bubble ID/EX register.
REQ-019 SHALL have port state_o  out  3  current FSM state, for the debug unit.
REQ-020 SHALL have port cycle_count  out  32  number of cycles spent in an executing state.

Function
REQ-021 SHALL implement the FSM states HALTED, RUN, STEP, DRAIN and DONE.
REQ-022 HALTED: dbg_step SHALL go to STEP; otherwise dbg_run SHALL go to RUN; dbg_step SHALL win if both are asserted.
REQ-023 STEP SHALL last exactly one cycle, then return to HALTED.
REQ-024 RUN: dbg_halt, or dbg_run deasserted, SHALL go to HALTED; halt_fetched SHALL go to DRAIN; dbg_halt SHALL win over halt_fetched.
REQ-025 DRAIN SHALL count down DRAIN_CYCLES cycles, ignoring dbg_run and dbg_step, then go to DONE.
REQ-026 In DRAIN, dbg_halt SHALL abort to HALTED.
REQ-027 DONE SHALL hold until reset; all debug commands in DONE SHALL be ignored.
REQ-028 "Active" SHALL mean the state is RUN or STEP; DRAIN is not active for fetch.
REQ-029 Outputs SHALL be combinational from the registered state and the current inputs, giving zero-cycle redirect latency.
REQ-030 Priority while active SHALL be: branch_taken > jump_valid > hazard_stall > sequential.
REQ-031 On branch_taken while active: pc_use_npc=0, pc_target=branch_target, flush_if_id=1, flush_id_ex=1.
REQ-032 On jump_valid without branch while active: pc_use_npc=0, pc_target=jump_target, flush_if_id=1, flush_id_ex=0.
REQ-033 On hazard_stall only while active: pc_stall=1, pc_use_npc=1, flush_id_ex=1, flush_if_id=0.
REQ-034 When not active (HALTED, DRAIN, DONE): pc_stall=1, pc_use_npc=1, and all redirects SHALL be suppressed.
REQ-035 In DRAIN, flush_if_id SHALL be 1 so that no instruction after the halt enters decode.
REQ-036 In the default sequential case, pc_target SHALL be 0.
REQ-037 pc_use_npc SHALL never be 0 outside RUN/STEP, because the PC loads its target regardless of stall.
REQ-038 cycle_count SHALL increment in RUN, STEP and DRAIN, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-039 Reset SHALL set: state=HALTED, drain counter=0, cycle_count=0.
REQ-040 Reset SHALL override all inputs in the same edge.
REQ-041 Output values during and after reset: pc_stall=1, pc_use_npc=1, pc_target=0, both flushes=0 (HALTED values).
REQ-042 Reset in any state, including mid-DRAIN, SHALL return the block to HALTED.

Structure
REQ-043 State encodings and the DRAIN_CYCLES default SHALL live in the shared MIPS package/header alongside the pipeline constants.
REQ-044 The drain down-counter SHALL be a natural sub-module, drain_timer (load, decrement, zero flag); everything else SHALL be a single module.

Verification
REQ-045 Reset, then dbg_run=1 for 5 cycles: RUN within 1 cycle; pc_stall=0, pc_use_npc=1; cycle_count=5 afterwards.
REQ-046 RUN with branch_taken=1, target 0x40, and jump_valid=1, target 0x80, in the same cycle: pc_use_npc=0, pc_target=0x40, both flushes=1.
REQ-047 RUN with hazard_stall=1 and jump_valid=1, target 0x10: jump wins; pc_use_npc=0, pc_target=0x10, pc_stall=0.
REQ-048 HALTED, then pulse dbg_step three times, spaced apart: exactly 3 cycles with pc_stall=0; cycle_count=3; state_o returns to HALTED each time.
REQ-049 RUN then halt_fetched=1: DRAIN for 4 cycles with pc_stall=1 and flush_if_id=1, then DONE; dbg_run is ignored afterwards.
REQ-050 Assert reset during the 2nd DRAIN cycle: next cycle shows HALTED, cycle_count=0, pc_use_npc=1.
